// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH = 24;

  // The bit counter has to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only if it is non-negative.
module div_sub_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH:0]   i_shifted_rem,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_next_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_diff;

  // One extra bit so the sign of the trial difference is visible.
  assign w_diff     = {1'b0, i_shifted_rem} - {2'b00, i_divisor};
  assign o_qbit     = ~w_diff[WIDTH+1];
  assign o_next_rem = o_qbit ? w_diff[WIDTH:0] : i_shifted_rem;

endmodule

// File: rtl/seq_divider_24.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional remainder output is built only when SEQ_DIV_REM_EN is defined.
module seq_divider_24
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_last_step;
  logic [WIDTH:0]   w_shifted_rem;
  logic [WIDTH:0]   w_next_rem;
  logic             w_qbit;
  logic [WIDTH-1:0] w_next_work;

  assign ready       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign done        = (r_state == S_DONE);
  assign w_accept    = start && ready;
  assign w_last_step = (r_state == S_RUN) && (r_count == CNT_W'(1));

  // r_work starts as the dividend and fills with quotient bits from the right.
  assign w_shifted_rem = {r_rem[WIDTH-1:0], r_work[WIDTH-1]};
  assign w_next_work   = {r_work[WIDTH-2:0], w_qbit};

  div_sub_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_shifted_rem(w_shifted_rem),
    .i_divisor    (r_divisor),
    .o_next_rem   (w_next_rem),
    .o_qbit       (w_qbit)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = (divisor == '0) ? S_ZERO : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN:   if (w_last_step) w_state_next = S_DONE;
      S_ZERO:  w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_work     <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_quotient <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_count    <= CNT_W'(WIDTH);
      r_work     <= dividend;
      r_rem      <= '0;
      r_divisor  <= divisor;
      r_div_zero <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_count <= r_count - CNT_W'(1);
      r_work  <= w_next_work;
      r_rem   <= w_next_rem;
      if (w_last_step) begin
        r_quotient <= w_next_work;
      end
    end else if (r_state == S_ZERO) begin
      r_quotient <= '1;
      r_div_zero <= 1'b1;
    end
  end

  assign quotient = r_quotient;
  assign div_zero = r_div_zero;

`ifdef SEQ_DIV_REM_EN
  logic [WIDTH-1:0] r_rem_out;

  // In ZERO the untouched dividend still sits in r_work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem_out <= '0;
    end else if (!w_accept) begin
      if (w_last_step) begin
        r_rem_out <= w_next_rem[WIDTH-1:0];
      end else if (r_state == S_ZERO) begin
        r_rem_out <= r_work;
      end
    end
  end

  assign remainder = r_rem_out;
`else
  assign remainder = '0;
`endif

endmodule

// File: tb/tb_seq_divider_24.sv
// Self-checking bench for seq_divider_24: directed cases plus random divides
// compared against plain integer division.
module tb_seq_divider_24;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        ready;
  logic        done;
  logic [23:0] quotient;
  logic [23:0] remainder;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  seq_divider_24 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; latency counted in clock edges from
  // the cycle start is raised until the cycle in which done is seen.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input string tag);
    int          n;
    bit          seen;
    logic [23:0] exp_q;
    logic [23:0] exp_r;
    int          exp_lat;
    exp_q   = (b == 0) ? 24'hFFFFFF : a / b;
    exp_r   = (b == 0) ? a : a % b;
`ifndef SEQ_DIV_REM_EN
    exp_r   = 24'h0;
`endif
    exp_lat = (b == 0) ? 2 : 25;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    n        = 0;
    seen     = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        chk({tag, "_busy"}, 32'(ready), 32'd0);
        start    = 1'b0;
        dividend = 24'($urandom);
        divisor  = 24'($urandom);
      end
      seen = done;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_q"}, 32'(quotient), 32'(exp_q));
    chk({tag, "_r"}, 32'(remainder), 32'(exp_r));
    chk({tag, "_dz"}, 32'(div_zero), 32'(b == 0));
    $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0b after %0d cycles",
             tag, a, b, quotient, remainder, div_zero, n);
  endtask

  task automatic idle_and_check_done_drop(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          pulses;
    int          n;
    logic [23:0] ra;
    logic [23:0] rb;
    logic [23:0] exp_q;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(24'd100, 24'd7, "d100_7");
    idle_and_check_done_drop("d100_7");
    run_op(24'hFFFFFF, 24'd1, "dmax_1");
    idle_and_check_done_drop("dmax_1");
    run_op(24'h000005, 24'h000009, "d5_9");
    idle_and_check_done_drop("d5_9");
    run_op(24'h123456, 24'd0, "dzero");
    idle_and_check_done_drop("dzero");
    run_op(24'd77, 24'd10, "after_zero");
    idle_and_check_done_drop("after_zero");

    // Back-to-back: second start raised in the DONE cycle of the first.
    run_op(24'd50, 24'd5, "b2b_a");
    run_op(24'd81, 24'd9, "b2b_b");
    idle_and_check_done_drop("b2b_b");

    // start held high with changing operands during RUN.
    dividend = 24'd1000;
    divisor  = 24'd7;
    start    = 1'b1;
    pulses   = 0;
    n        = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      dividend = 24'($urandom);
      divisor  = 24'($urandom);
      if (done) pulses++;
    end
    start = 1'b0;
    while (pulses == 0 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) pulses++;
    end
    chk("hold_lat", 32'(n), 32'd25);
    chk("hold_q", 32'(quotient), 32'd142);
`ifdef SEQ_DIV_REM_EN
    chk("hold_r", 32'(remainder), 32'd6);
`else
    chk("hold_r", 32'(remainder), 32'd0);
`endif
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("hold_pulses", 32'(pulses), 32'd1);
    $display("op hold: 1000 / 7 -> q=%0d pulses=%0d", quotient, pulses);

    // Asynchronous reset in the middle of RUN.
    dividend = 24'd600;
    divisor  = 24'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_pulses", 32'(pulses), 32'd0);
    $display("op abort: reset during RUN, done pulses afterwards=%0d", pulses);
    run_op(24'd9, 24'd3, "d9_3");
    idle_and_check_done_drop("d9_3");

    // Random divides, with an occasional zero or tiny divisor.
    for (int i = 0; i < 10; i++) begin
      ra = 24'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 24'd0;
        1:       rb = 24'($urandom_range(1, 15));
        2:       rb = 24'($urandom_range(1, 4095));
        default: rb = 24'($urandom);
      endcase
      run_op(ra, rb, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle_and_check_done_drop($sformatf("rnd%0d", i));
    end

    // Final random back-to-back pair exercising start in DONE.
    ra    = 24'($urandom);
    rb    = 24'($urandom_range(1, 255));
    exp_q = ra / rb;
    run_op(ra, rb, "rnd_b2b_a");
    run_op(24'($urandom), 24'($urandom_range(1, 65535)), "rnd_b2b_b");
    idle_and_check_done_drop("rnd_b2b_b");
    chk("rnd_b2b_model", 32'(exp_q), 32'(ra / rb));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
